// File: rtl/uart_tx_fifo_if.sv
// Write-side valid/ready handshake between a word-producing core and uart_tx_fifo.
interface uart_tx_fifo_if #(
    parameter int DATA_BITS = 8
);
    logic [DATA_BITS-1:0] data;
    logic                 data_valid;
    logic                 data_ready;

    modport master (output data, output data_valid, input data_ready);
    modport slave  (input data, input data_valid, output data_ready);
endinterface

// File: rtl/uart_tx_fifo.sv
// UART transmitter with a write FIFO, configurable word width, optional parity
// and one or two stop bits; frames are sent back to back while words are queued.
module uart_tx_fifo #(
    parameter int CLKS_PER_BIT = 868,
    parameter int DATA_BITS    = 8,
    parameter int PARITY       = 0,
    parameter int STOP_BITS    = 1,
    parameter int FIFO_DEPTH   = 16
) (
    input  logic                        clk,
    input  logic                        rst,
    uart_tx_fifo_if.slave               host,
    output logic                        tx,
    output logic                        busy,
    output logic                        tx_done,
    output logic [$clog2(FIFO_DEPTH):0] fifo_count
);
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int BW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [BW-1:0] BAUD_LAST   = BW'(CLKS_PER_BIT - 1);
    localparam logic [3:0]    DATA_LAST   = 4'(DATA_BITS - 1);
    localparam logic [3:0]    STOP_LAST   = 4'(STOP_BITS - 1);
    localparam logic [AW:0]   FULL_COUNT  = (AW+1)'(FIFO_DEPTH);
    localparam logic [AW:0]   EMPTY_COUNT = (AW+1)'(0);
    localparam logic          HAS_PARITY  = (PARITY != 0);

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_START  = 3'd1,
        ST_DATA   = 3'd2,
        ST_PARITY = 3'd3,
        ST_STOP   = 3'd4
    } state_t;

    state_t                 state_r;
    logic [BW-1:0]          baud_r;
    logic [3:0]             bit_cnt_r;
    logic [DATA_BITS-1:0]   shreg_r;
    logic                   par_r;

    logic [DATA_BITS-1:0]   mem_r [FIFO_DEPTH];
    logic [AW-1:0]          wr_ptr_r;
    logic [AW-1:0]          rd_ptr_r;
    logic [AW:0]            count_r;

    logic                   push_s;
    logic                   pop_s;
    logic                   frame_end_s;
    logic [DATA_BITS-1:0]   rd_word_s;

    // Odd parity makes the total count of ones (data plus parity) odd.
    function automatic logic parity_bit(input logic [DATA_BITS-1:0] word);
        logic p;
        if (PARITY == 1) begin
            p = ~(^word);
        end else begin
            p = ^word;
        end
        return p;
    endfunction

    // Handshake and pop decode; pops happen only when a new frame is launched.
    always_comb begin
        push_s      = host.data_valid && (count_r != FULL_COUNT);
        frame_end_s = (state_r == ST_STOP) && (baud_r == BAUD_LAST) && (bit_cnt_r == STOP_LAST);
        rd_word_s   = mem_r[rd_ptr_r];
        if (count_r != EMPTY_COUNT) begin
            pop_s = (state_r == ST_IDLE) || frame_end_s;
        end else begin
            pop_s = 1'b0;
        end
    end

    assign host.data_ready = (count_r != FULL_COUNT);
    assign busy            = (state_r != ST_IDLE) || (count_r != EMPTY_COUNT);
    assign fifo_count      = count_r;

    // FIFO storage; contents need no reset because the count gates every read.
    always_ff @(posedge clk) begin
        if (push_s) begin
            mem_r[wr_ptr_r] <= host.data;
        end
    end

    // FIFO pointers and occupancy; a push and pop on the same edge cancel out.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_r <= {AW{1'b0}};
            rd_ptr_r <= {AW{1'b0}};
            count_r  <= EMPTY_COUNT;
        end else begin
            if (push_s) begin
                wr_ptr_r <= wr_ptr_r + AW'(1);
            end
            if (pop_s) begin
                rd_ptr_r <= rd_ptr_r + AW'(1);
            end
            case ({push_s, pop_s})
                2'b10:   count_r <= count_r + (AW+1)'(1);
                2'b01:   count_r <= count_r - (AW+1)'(1);
                default: count_r <= count_r;
            endcase
        end
    end

    // Frame sequencer; tx is loaded with the next bit value on each bit boundary.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r   <= ST_IDLE;
            baud_r    <= BW'(0);
            bit_cnt_r <= 4'd0;
            shreg_r   <= {DATA_BITS{1'b0}};
            par_r     <= 1'b0;
            tx        <= 1'b1;
            tx_done   <= 1'b0;
        end else begin
            tx_done <= 1'b0;
            case (state_r)
                ST_IDLE: begin
                    baud_r    <= BW'(0);
                    bit_cnt_r <= 4'd0;
                    if (pop_s) begin
                        shreg_r <= rd_word_s;
                        par_r   <= parity_bit(rd_word_s);
                        tx      <= 1'b0;
                        state_r <= ST_START;
                    end else begin
                        tx <= 1'b1;
                    end
                end
                ST_START: begin
                    if (baud_r == BAUD_LAST) begin
                        baud_r  <= BW'(0);
                        tx      <= shreg_r[0];
                        state_r <= ST_DATA;
                    end else begin
                        baud_r <= baud_r + BW'(1);
                    end
                end
                ST_DATA: begin
                    if (baud_r == BAUD_LAST) begin
                        baud_r <= BW'(0);
                        if (bit_cnt_r == DATA_LAST) begin
                            bit_cnt_r <= 4'd0;
                            if (HAS_PARITY) begin
                                tx      <= par_r;
                                state_r <= ST_PARITY;
                            end else begin
                                tx      <= 1'b1;
                                state_r <= ST_STOP;
                            end
                        end else begin
                            bit_cnt_r <= bit_cnt_r + 4'd1;
                            shreg_r   <= shreg_r >> 1;
                            tx        <= shreg_r[1];
                        end
                    end else begin
                        baud_r <= baud_r + BW'(1);
                    end
                end
                ST_PARITY: begin
                    if (baud_r == BAUD_LAST) begin
                        baud_r  <= BW'(0);
                        tx      <= 1'b1;
                        state_r <= ST_STOP;
                    end else begin
                        baud_r <= baud_r + BW'(1);
                    end
                end
                ST_STOP: begin
                    if (baud_r == BAUD_LAST) begin
                        baud_r <= BW'(0);
                        if (bit_cnt_r == STOP_LAST) begin
                            bit_cnt_r <= 4'd0;
                            tx_done   <= 1'b1;
                            // A queued word starts its start bit on this same edge.
                            if (pop_s) begin
                                shreg_r <= rd_word_s;
                                par_r   <= parity_bit(rd_word_s);
                                tx      <= 1'b0;
                                state_r <= ST_START;
                            end else begin
                                tx      <= 1'b1;
                                state_r <= ST_IDLE;
                            end
                        end else begin
                            bit_cnt_r <= bit_cnt_r + 4'd1;
                        end
                    end else begin
                        baud_r <= baud_r + BW'(1);
                    end
                end
                default: begin
                    state_r <= ST_IDLE;
                    tx      <= 1'b1;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_uart_tx_fifo.sv
// Bench for uart_tx_fifo: three configurations (8N1 depth 4, 7E2 and 7O1 depth 2)
// checked every cycle against a frame-level model plus directed literal checks.
module tb_uart_tx_fifo;
    localparam int CPB = 4;

    logic       clk;
    logic       rst;
    logic [2:0] vld;
    logic [7:0] din [3];

    logic       tx0, tx1, tx2, busy0, busy1, busy2, done0, done1, done2;
    logic [2:0] cnt0;
    logic [1:0] cnt1, cnt2;
    logic [2:0] tx_v, busy_v, done_v, rdy_v;

    uart_tx_fifo_if #(.DATA_BITS(8)) if0 ();
    uart_tx_fifo_if #(.DATA_BITS(7)) if1 ();
    uart_tx_fifo_if #(.DATA_BITS(7)) if2 ();

    assign if0.data = din[0];
    assign if1.data = din[1][6:0];
    assign if2.data = din[2][6:0];
    assign if0.data_valid = vld[0];
    assign if1.data_valid = vld[1];
    assign if2.data_valid = vld[2];
    assign tx_v   = {tx2, tx1, tx0};
    assign busy_v = {busy2, busy1, busy0};
    assign done_v = {done2, done1, done0};
    assign rdy_v  = {if2.data_ready, if1.data_ready, if0.data_ready};

    uart_tx_fifo #(.CLKS_PER_BIT(CPB), .DATA_BITS(8), .PARITY(0), .STOP_BITS(1), .FIFO_DEPTH(4)) dut0 (
        .clk(clk), .rst(rst), .host(if0), .tx(tx0), .busy(busy0), .tx_done(done0), .fifo_count(cnt0));
    uart_tx_fifo #(.CLKS_PER_BIT(CPB), .DATA_BITS(7), .PARITY(2), .STOP_BITS(2), .FIFO_DEPTH(2)) dut1 (
        .clk(clk), .rst(rst), .host(if1), .tx(tx1), .busy(busy1), .tx_done(done1), .fifo_count(cnt1));
    uart_tx_fifo #(.CLKS_PER_BIT(CPB), .DATA_BITS(7), .PARITY(1), .STOP_BITS(1), .FIFO_DEPTH(2)) dut2 (
        .clk(clk), .rst(rst), .host(if2), .tx(tx2), .busy(busy2), .tx_done(done2), .fifo_count(cnt2));

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    int tests = 0;
    int fails = 0;

    task automatic chk(input string name, input int act, input int exp);
        tests++;
        if (act != exp) begin
            fails++;
            $display("FAIL %s: got %0d, expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    function automatic int db_of(input int i);
        case (i)
            0:       return 8;
            default: return 7;
        endcase
    endfunction
    function automatic int par_of(input int i);
        case (i)
            1:       return 2;
            2:       return 1;
            default: return 0;
        endcase
    endfunction
    function automatic int stp_of(input int i);
        case (i)
            1:       return 2;
            default: return 1;
        endcase
    endfunction
    function automatic int dep_of(input int i);
        case (i)
            0:       return 4;
            default: return 2;
        endcase
    endfunction
    function automatic int cnt_of(input int i);
        case (i)
            0:       return int'(cnt0);
            1:       return int'(cnt1);
            default: return int'(cnt2);
        endcase
    endfunction
    function automatic int flen(input int i);
        return (1 + db_of(i) + ((par_of(i) != 0) ? 1 : 0) + stp_of(i)) * CPB;
    endfunction
    // Line level t cycles after a frame of word w started.
    function automatic int frame_bit(input int i, input int w, input int t);
        int b = t / CPB;
        int ones = 0;
        if (b == 0) return 0;
        if (b <= db_of(i)) return (w >> (b - 1)) & 1;
        if (par_of(i) != 0 && b == db_of(i) + 1) begin
            for (int k = 0; k < db_of(i); k++) ones += (w >> k) & 1;
            if (par_of(i) == 1) return ((ones % 2) == 0) ? 1 : 0;
            return ones % 2;
        end
        return 1;
    endfunction

    // Model: FIFO contents as a ring of ints, plus "in frame / cycles since start".
    int m_cnt [3];
    int m_act [3];
    int m_t   [3];
    int m_cur [3];
    int m_done[3];
    int q     [3][16];
    int qh    [3];
    int qt    [3];
    int acc_log [64];
    int acc_n = 0;
    bit started = 1'b0;
    bit m_push;
    int m_w;

    initial forever begin
        @(posedge clk);
        for (int i = 0; i < 3; i++) begin
            if (rst) begin
                m_cnt[i] = 0; m_act[i] = 0; m_t[i] = 0; m_done[i] = 0;
                qh[i] = 0; qt[i] = 0;
                started = 1'b1;
            end else begin
                m_push = vld[i] && (m_cnt[i] != dep_of(i));
                m_done[i] = 0;
                if (m_act[i] != 0) begin
                    m_t[i]++;
                    if (m_t[i] == flen(i)) begin
                        m_done[i] = 1;
                        m_act[i] = 0;
                    end
                end
                if (m_act[i] == 0 && m_cnt[i] > 0) begin
                    m_cur[i] = q[i][qh[i]];
                    qh[i] = (qh[i] + 1) % 16;
                    m_cnt[i]--;
                    m_act[i] = 1;
                    m_t[i] = 0;
                end
                if (m_push) begin
                    m_w = int'(din[i]) & ((1 << db_of(i)) - 1);
                    q[i][qt[i]] = m_w;
                    qt[i] = (qt[i] + 1) % 16;
                    m_cnt[i]++;
                    if (i == 0 && acc_n < 64) begin
                        acc_log[acc_n] = m_w;
                        acc_n++;
                    end
                end
            end
        end
    end

    // Per-cycle comparison of every output against the model.
    initial forever begin
        @(negedge clk);
        if (started) begin
            for (int i = 0; i < 3; i++) begin
                chk($sformatf("tx%0d", i), int'(tx_v[i]),
                    (m_act[i] != 0) ? frame_bit(i, m_cur[i], m_t[i]) : 1);
                chk($sformatf("busy%0d", i), int'(busy_v[i]),
                    (m_act[i] != 0 || m_cnt[i] != 0) ? 1 : 0);
                chk($sformatf("tx_done%0d", i), int'(done_v[i]), m_done[i]);
                chk($sformatf("fifo_count%0d", i), cnt_of(i), m_cnt[i]);
                chk($sformatf("data_ready%0d", i), int'(rdy_v[i]),
                    (m_cnt[i] != dep_of(i)) ? 1 : 0);
            end
        end
    end

    task automatic tick();
        @(negedge clk);
    endtask

    task automatic wait_idle(input int idx, input int maxc);
        int n = 0;
        while (busy_v[idx] && n < maxc) begin
            tick();
            n++;
        end
        chk("idle_timeout", int'(busy_v[idx]), 0);
    endtask

    logic [9:0] a5_seq;
    int hi;
    int npulse;
    int ptime [3];
    int n0;
    int got;

    initial begin
        rst = 1'b1;
        vld = 3'b000;
        din[0] = 8'h00; din[1] = 8'h00; din[2] = 8'h00;
        a5_seq = 10'b1101001010;
        ptime[0] = 0; ptime[1] = 0; ptime[2] = 0;
        repeat (3) tick();
        chk("rst_tx", int'(tx_v), 7);
        chk("rst_busy", int'(busy_v), 0);
        chk("rst_done", int'(done_v), 0);
        chk("rst_ready", int'(rdy_v), 7);
        chk("rst_cnt0", int'(cnt0), 0);
        rst = 1'b0;
        tick();

        // Single 8N1 frame of 0xA5.
        din[0] = 8'hA5; vld[0] = 1'b1; tick(); vld[0] = 1'b0; tick();
        for (int c = 0; c < 40; c++) begin
            if (c % 4 == 1) chk("a5_bit", int'(tx_v[0]), int'(a5_seq[c / 4]));
            tick();
        end
        chk("a5_done", int'(done_v[0]), 1);
        chk("a5_busy_end", int'(busy_v[0]), 0);
        tick();
        chk("a5_done_once", int'(done_v[0]), 0);

        // 0x03 on 7E2 and 7O1 together.
        din[1] = 8'h03; din[2] = 8'h03; vld[2:1] = 2'b11; tick(); vld[2:1] = 2'b00; tick();
        hi = 0;
        for (int c = 0; c <= 44; c++) begin
            if (c == 33) begin
                chk("even_parity", int'(tx_v[1]), 0);
                chk("odd_parity", int'(tx_v[2]), 1);
            end
            if (c == 35) chk("even_parity_end", int'(tx_v[1]), 0);
            if (c >= 36 && c < 44) hi += int'(tx_v[1]);
            if (c == 40) chk("odd_done", int'(done_v[2]), 1);
            if (c == 44) chk("even2_done", int'(done_v[1]), 1);
            if (c < 44) tick();
        end
        chk("stop2_high", hi, 8);
        tick();

        // Back-to-back frames.
        din[0] = 8'h55; vld[0] = 1'b1; tick();
        din[0] = 8'h0F; tick();
        din[0] = 8'hFF; tick();
        vld[0] = 1'b0;
        npulse = 0;
        for (int c = 0; c < 160; c++) begin
            if (done_v[0]) begin
                if (npulse < 3) ptime[npulse] = c;
                npulse++;
                if (npulse < 3) chk("b2b_no_gap", int'(tx_v[0]), 0);
            end
            tick();
        end
        chk("b2b_pulses", npulse, 3);
        chk("b2b_gap1", ptime[1] - ptime[0], 40);
        chk("b2b_gap2", ptime[2] - ptime[1], 40);

        // Overfill a depth-4 FIFO with an incrementing stream.
        n0 = acc_n;
        din[0] = 8'h10; vld[0] = 1'b1;
        for (int k = 0; k < 10; k++) begin
            tick();
            din[0] = din[0] + 8'd1;
        end
        vld[0] = 1'b0;
        chk("full_cnt", int'(cnt0), 4);
        chk("full_ready", int'(rdy_v[0]), 0);
        chk("full_accepted", acc_n - n0, 5);
        for (int k = 0; k < 5; k++) chk("full_order", acc_log[n0 + k], 16 + k);
        wait_idle(0, 400);

        // Reset during data bit 3 with two words queued.
        din[0] = 8'h81; vld[0] = 1'b1; tick();
        din[0] = 8'h42; tick();
        din[0] = 8'h24; tick();
        vld[0] = 1'b0;
        repeat (16) tick();
        chk("mid_cnt", int'(cnt0), 2);
        rst = 1'b1; tick(); rst = 1'b0;
        chk("rst_mid_tx", int'(tx_v[0]), 1);
        chk("rst_mid_cnt", int'(cnt0), 0);
        chk("rst_mid_busy", int'(busy_v[0]), 0);
        chk("rst_mid_done", int'(done_v[0]), 0);
        npulse = 0;
        for (int c = 0; c < 50; c++) begin
            npulse += int'(done_v[0]);
            tick();
        end
        chk("rst_no_done", npulse, 0);
        din[0] = 8'h3C; vld[0] = 1'b1; tick(); vld[0] = 1'b0; tick();
        chk("post_rst_start", int'(tx_v[0]), 0);
        got = 0;
        for (int c = 0; c < 60 && got == 0; c++) begin
            tick();
            got = int'(done_v[0]);
        end
        chk("post_rst_frame", got, 1);

        // Push on the pop edge.
        din[0] = 8'h11; vld[0] = 1'b1; tick();
        din[0] = 8'h22; tick();
        vld[0] = 1'b0;
        chk("pp_cnt", int'(cnt0), 1);
        for (int c = 0; c <= 49; c++) begin
            if (c == 9) chk("pp_w1_bit1", int'(tx_v[0]), 0);
            if (c == 40) begin
                chk("pp_done", int'(done_v[0]), 1);
                chk("pp_start2", int'(tx_v[0]), 0);
            end
            if (c == 45) chk("pp_w2_bit0", int'(tx_v[0]), 0);
            if (c == 49) chk("pp_w2_bit1", int'(tx_v[0]), 1);
            tick();
        end
        wait_idle(0, 100);

        @(posedge clk);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
